// File: rtl/fpu_mul_seq_if.sv
// Operand/result bundle between the command controller and the sequential multiplier.
interface fpu_mul_seq_if #(
    parameter int unsigned MANT_W = 15,
    parameter int unsigned EXP_W  = 7
);
    logic              start;
    logic              reg1_s;
    logic [EXP_W-1:0]  reg1_e;
    logic [MANT_W-1:0] reg1_m;
    logic              reg2_s;
    logic [EXP_W-1:0]  reg2_e;
    logic [MANT_W-1:0] reg2_m;
    logic              res_s;
    logic [EXP_W-1:0]  res_e;
    logic [MANT_W-1:0] res_m;
    logic              zero_flag;
    logic              overflow_flag;
    logic              underflow_flag;
    logic              done;
    logic              idle;

    modport master (
        output start, reg1_s, reg1_e, reg1_m, reg2_s, reg2_e, reg2_m,
        input  res_s, res_e, res_m, zero_flag, overflow_flag, underflow_flag, done, idle
    );

    modport slave (
        input  start, reg1_s, reg1_e, reg1_m, reg2_s, reg2_e, reg2_m,
        output res_s, res_e, res_m, zero_flag, overflow_flag, underflow_flag, done, idle
    );
endinterface

// File: rtl/fpu_mul_seq.sv
// 18-cycle shift-add multiplier for the sign/exponent/mantissa float format.
// Optional FPU_MUL_ROUND_EN: round half-up instead of truncating the mantissa.
module fpu_mul_seq #(
    parameter int unsigned MANT_W = 15,
    parameter int unsigned EXP_W  = 7
) (
    input logic          clk,
    input logic          reset,
    fpu_mul_seq_if.slave bus
);
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned CNT_W  = $clog2(SIG_W);
    localparam int unsigned ESUM_W = EXP_W + 3;
    localparam logic [EXP_W-1:0]         EXP_ZERO = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]         EXP_MAX  = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic signed [ESUM_W-1:0] E_HI     = ESUM_W'(EXP_MAX);
    localparam logic signed [ESUM_W-1:0] E_LO     = -E_HI;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SIG_W - 1);

    typedef enum logic [1:0] {IDLE, MULT, NORM} state_e;

    state_e                     state_q;
    logic [SIG_W-1:0]           a_q, b_q;
    logic [PROD_W-1:0]          acc_q;
    logic [CNT_W-1:0]           cnt_q;
    logic signed [ESUM_W-1:0]   esum_q;
    logic                       sign_q, zin_q;
    logic                       res_s_q;
    logic [EXP_W-1:0]           res_e_q;
    logic [MANT_W-1:0]          res_m_q;
    logic                       zero_q, ovf_q, unf_q, done_q, idle_q;

    logic                       p_msb;
    logic [MANT_W-1:0]          m_raw, m_fin;
    logic signed [ESUM_W-1:0]   e_raw, e_fin;
    logic                       res_s_d;
    logic [EXP_W-1:0]           res_e_d;
    logic [MANT_W-1:0]          res_m_d;
    logic                       zero_d, ovf_d, unf_d;

    // Normalise: product of two 1.x values lies in [1,4)
    assign p_msb = acc_q[PROD_W-1];
    assign m_raw = p_msb ? acc_q[PROD_W-2 -: MANT_W] : acc_q[PROD_W-3 -: MANT_W];
    assign e_raw = esum_q + ESUM_W'(p_msb);

`ifdef FPU_MUL_ROUND_EN
    logic rnd_bit, rnd_cy;
    assign rnd_bit = p_msb ? acc_q[PROD_W-MANT_W-2] : acc_q[PROD_W-MANT_W-3];
    // A carry out of the stored mantissa means 1.11..1 rounded up to 10.00..0
    assign {rnd_cy, m_fin} = (MANT_W+1)'(m_raw) + (MANT_W+1)'(rnd_bit);
    assign e_fin = rnd_cy ? e_raw + ESUM_W'(1) : e_raw;
`else
    assign m_fin = m_raw;
    assign e_fin = e_raw;
`endif

    always_comb begin
        res_s_d = sign_q;
        res_e_d = e_fin[EXP_W-1:0];
        res_m_d = m_fin;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (zin_q) begin
            res_s_d = 1'b0;
            res_e_d = EXP_ZERO;
            res_m_d = '0;
            zero_d  = 1'b1;
        end else if (e_fin > E_HI) begin
            res_e_d = EXP_MAX;
            res_m_d = '1;
            ovf_d   = 1'b1;
        end else if (e_fin < E_LO) begin
            res_s_d = 1'b0;
            res_e_d = EXP_ZERO;
            res_m_d = '0;
            zero_d  = 1'b1;
            unf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            esum_q  <= '0;
            sign_q  <= 1'b0;
            zin_q   <= 1'b0;
            res_s_q <= 1'b0;
            res_e_q <= '0;
            res_m_q <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= {1'b1, bus.reg1_m};
                        b_q     <= {1'b1, bus.reg2_m};
                        sign_q  <= bus.reg1_s ^ bus.reg2_s;
                        esum_q  <= ESUM_W'($signed(bus.reg1_e)) + ESUM_W'($signed(bus.reg2_e));
                        zin_q   <= (bus.reg1_e == EXP_ZERO) | (bus.reg2_e == EXP_ZERO);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        idle_q  <= 1'b0;
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    if (b_q[0]) acc_q <= acc_q + (PROD_W'(a_q) << cnt_q);
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) state_q <= NORM;
                end
                NORM: begin
                    res_s_q <= res_s_d;
                    res_e_q <= res_e_d;
                    res_m_q <= res_m_d;
                    zero_q  <= zero_d;
                    ovf_q   <= ovf_d;
                    unf_q   <= unf_d;
                    done_q  <= 1'b1;
                    idle_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.res_s          = res_s_q;
    assign bus.res_e          = res_e_q;
    assign bus.res_m          = res_m_q;
    assign bus.zero_flag      = zero_q;
    assign bus.overflow_flag  = ovf_q;
    assign bus.underflow_flag = unf_q;
    assign bus.done           = done_q;
    assign bus.idle           = idle_q;
endmodule
